vec_maindec_seq: RTL

- Parametrised, registered successor to the single-cycle main decoder for the scalar/vector processor.
- Decodes the 6-bit opcode into the 14-bit control word and tracks program run state (start/close).
- Expands vector load/store into multi-beat sequences when the vector is wider than the memory port.
- Sits between the fetch/decode register and the execute stage. Drives a stall request back to fetch during beat expansion.

---
 rtl/vec_ctrl_pkg.sv | 74 +++++++
 rtl/maindec_comb.sv | 20 ++
 rtl/vec_maindec_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/vec_ctrl_pkg.sv
// Shared types for the registered scalar/vector main decoder: opcode map,
// control-word layout, sequencer states and the opcode lookup function.
package vec_ctrl_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD    = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI   = 6'b010000;
  localparam logic [OP_W-1:0] OP_FP     = 6'b000100;
  localparam logic [OP_W-1:0] OP_VFP    = 6'b001100;
  localparam logic [OP_W-1:0] OP_SW     = 6'b010001;
  localparam logic [OP_W-1:0] OP_LW     = 6'b010010;
  localparam logic [OP_W-1:0] OP_SWFP   = 6'b010101;
  localparam logic [OP_W-1:0] OP_LWFP   = 6'b010110;
  localparam logic [OP_W-1:0] OP_VST    = 6'b011101;
  localparam logic [OP_W-1:0] OP_VLD    = 6'b011110;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'b100000;
  localparam logic [OP_W-1:0] OP_BLT    = 6'b100001;
  localparam logic [OP_W-1:0] OP_J      = 6'b100010;
  localparam logic [OP_W-1:0] OP_VSETFP = 6'b111111;
  localparam logic [OP_W-1:0] OP_START  = 6'b110010;
  localparam logic [OP_W-1:0] OP_CLOSE  = 6'b110001;

  typedef struct packed {
    logic       reg_write;
    logic       vreg_write;
    logic       memto_reg;
    logic       mem_write;
    logic       mem_data;
    logic       mem_src;
    logic       alu_src;
    logic       scalar;
    logic       reg_dst;
    logic [1:0] branch;
    logic       jump;
    logic [1:0] aluop;
  } ctrl_t;

  typedef enum logic [1:0] {IDLE, RUN, BEAT, HALT} state_e;

  typedef struct packed {
    ctrl_t ctrl;
    logic  legal;
    logic  vmem;
  } dec_t;

  function automatic dec_t decode_op(input logic [OP_W-1:0] op);
    dec_t d;
    d       = '0;
    d.legal = 1'b1;
    case (op)
      OP_ADD:    d.ctrl = 14'b10_0000_001_00_0_10;
      OP_ADDI:   d.ctrl = 14'b10_0000_100_00_0_00;
      OP_FP:     d.ctrl = 14'b01_0000_011_00_0_10;
      OP_VFP:    d.ctrl = 14'b01_0000_001_00_0_10;
      OP_SW:     d.ctrl = 14'b00_0100_100_00_0_00;
      OP_LW:     d.ctrl = 14'b10_1000_100_00_0_00;
      OP_SWFP:   d.ctrl = 14'b00_0110_100_00_0_00;
      OP_LWFP:   d.ctrl = 14'b01_1010_100_00_0_00;
      OP_VST:    d.ctrl = 14'b00_0101_100_00_0_00;
      OP_VLD:    d.ctrl = 14'b01_1001_100_00_0_00;
      OP_BEQ:    d.ctrl = 14'b00_0000_000_01_0_00;
      OP_BLT:    d.ctrl = 14'b00_0000_000_10_0_00;
      OP_J:      d.ctrl = 14'b00_0000_000_00_1_00;
      OP_VSETFP: d.ctrl = 14'b01_0000_100_00_0_00;
      OP_START:  d.ctrl = '0;
      OP_CLOSE:  d.ctrl = '0;
      default:   d.legal = 1'b0;
    endcase
    d.vmem = (op == OP_VLD) || (op == OP_VST);
    return d;
  endfunction

endpackage

// File: rtl/maindec_comb.sv
// Combinational opcode lookup: control word, legality and vector-memory flag.
module maindec_comb
  import vec_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output ctrl_t           ctrl,
  output logic            legal,
  output logic            vmem
);

  dec_t d;

  always_comb begin
    d     = decode_op(op);
    ctrl  = d.ctrl;
    legal = d.legal;
    vmem  = d.vmem;
  end

endmodule

// File: rtl/vec_maindec_seq.sv
// Registered main decoder with run-state tracking and vld/vst beat expansion.
// Handshake: ctrl is consumed by execute whenever ctrl_valid=1 and hold=0;
// fetch keeps op stable on any cycle that follows stall_req=1.
module vec_maindec_seq
  import vec_ctrl_pkg::*;
#(
  parameter int OPW       = 6,
  parameter int VLANES    = 8,
  parameter int MEM_LANES = 2,
  parameter int BEATS     = VLANES / MEM_LANES,
  localparam int BW       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] op,
  input  logic           op_valid,
  input  logic           hold,
  input  logic           flush,
  output logic [13:0]    ctrl,
  output logic           ctrl_valid,
  output logic [BW-1:0]  beat_idx,
  output logic           last_beat,
  output logic           stall_req,
  output logic           running,
  output logic           halted,
  output logic           illegal_op,
  output state_e         state
);

  localparam logic [BW-1:0] LAST_IDX = BW'(BEATS - 1);

  logic [OP_W-1:0] op_dec;
  ctrl_t           dec_ctrl;
  logic            dec_legal;
  logic            dec_vmem;
  ctrl_t           ctrl_q;
  logic [BW-1:0]   beat_nx;

  assign op_dec  = OP_W'(op);
  assign beat_nx = beat_idx + BW'(1);

  maindec_comb u_dec (
    .op    (op_dec),
    .ctrl  (dec_ctrl),
    .legal (dec_legal),
    .vmem  (dec_vmem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ctrl_q     <= '0;
      ctrl_valid <= 1'b0;
      beat_idx   <= '0;
      last_beat  <= 1'b0;
      stall_req  <= 1'b0;
      illegal_op <= 1'b0;
    end else if (hold) begin
      // Everything freezes, but the illegal pulse must not stretch.
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= 1'b0;
      stall_req  <= 1'b0;
      last_beat  <= 1'b0;
      if (flush) begin
        ctrl_q     <= '0;
        ctrl_valid <= 1'b0;
        beat_idx   <= '0;
        if (state == BEAT) state <= RUN;
      end else begin
        case (state)
          IDLE: begin
            ctrl_q     <= '0;
            ctrl_valid <= 1'b0;
            beat_idx   <= '0;
            if (op_valid && op_dec == OP_START) state <= RUN;
          end
          RUN: begin
            ctrl_q     <= '0;
            ctrl_valid <= 1'b0;
            beat_idx   <= '0;
            if (op_valid) begin
              if (!dec_legal) begin
                illegal_op <= 1'b1;
              end else begin
                ctrl_q     <= dec_ctrl;
                ctrl_valid <= 1'b1;
                if (dec_vmem && BEATS > 1) begin
                  stall_req <= 1'b1;
                  state     <= BEAT;
                end else begin
                  last_beat <= 1'b1;
                  if (op_dec == OP_CLOSE) state <= HALT;
                end
              end
            end
          end
          BEAT: begin
            // ctrl_q is left untouched so every beat repeats the same word.
            ctrl_valid <= 1'b1;
            beat_idx   <= beat_nx;
            if (beat_nx == LAST_IDX) begin
              last_beat <= 1'b1;
              state     <= RUN;
            end else begin
              stall_req <= 1'b1;
            end
          end
          HALT: begin
            ctrl_q     <= '0;
            ctrl_valid <= 1'b0;
            beat_idx   <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign ctrl    = ctrl_q;
  assign running = (state == RUN) || (state == BEAT);
  assign halted  = (state == HALT);

endmodule
